// File: rtl/chunk_dot_pkg.sv
// Shared types and constants for the chunked dot-product engine.
package chunk_dot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAC     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_REQUANT = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  localparam int ACC_WIDTH_DEF = 32;

  // Width of a full chunk dot sum: one signed product plus growth for the adds.
  function automatic int dot_width(input int elem_w, input int elems);
    return 2 * elem_w + $clog2(elems);
  endfunction

endpackage

// File: rtl/chunk_dot.sv
// Registered signed dot product of two packed chunks, with clear and load enable.
module chunk_dot
  import chunk_dot_pkg::*;
#(
  parameter int WRITE_WIDTH    = 8,
  parameter int READ_WIDTH_MUL = 27,
  parameter int DOT_W          = dot_width(WRITE_WIDTH, READ_WIDTH_MUL)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr_i,
  input  logic                                  ld_i,
  input  logic [READ_WIDTH_MUL*WRITE_WIDTH-1:0] a_i,
  input  logic [READ_WIDTH_MUL*WRITE_WIDTH-1:0] b_i,
  output logic [DOT_W-1:0]                      dot_o
);

  localparam int PROD_W = 2 * WRITE_WIDTH;

  logic signed [PROD_W-1:0] prod_s;
  logic        [DOT_W-1:0]  dot_d;
  logic        [DOT_W-1:0]  dot_q;

  // Sum of element-wise signed products across the chunk.
  always_comb begin
    dot_d  = '0;
    prod_s = '0;
    for (int i = 0; i < READ_WIDTH_MUL; i++) begin
      prod_s = $signed(a_i[i*WRITE_WIDTH +: WRITE_WIDTH]) * $signed(b_i[i*WRITE_WIDTH +: WRITE_WIDTH]);
      dot_d  = dot_d + {{(DOT_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    end
  end

  // Dot register: cleared at job start, loaded on each accepted chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      dot_q <= '0;
    end else if (clr_i) begin
      dot_q <= '0;
    end else if (ld_i) begin
      dot_q <= dot_d;
    end else begin
      dot_q <= dot_q;
    end
  end

  assign dot_o = dot_q;

endmodule

// File: rtl/chunk_dot_engine.sv
// One-neuron chunked MAC engine: accumulate chunk dot products, add bias, requantise.
// Optional macro CHUNK_DOT_RELU_EN clamps the result at zero (ReLU) before saturation.
module chunk_dot_engine
  import chunk_dot_pkg::*;
#(
  parameter int WRITE_WIDTH    = 8,
  parameter int READ_WIDTH_MUL = 27,
  parameter int NUM_CHUNKS     = 35,
  parameter int ACC_WIDTH      = ACC_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [$clog2(NUM_CHUNKS)-1:0]         base_chunk,
  input  logic [$clog2(NUM_CHUNKS):0]           num_chunks,
  input  logic [ACC_WIDTH-1:0]                  bias,
  input  logic [4:0]                            shift,
  output logic                                  busy,
  output logic                                  rp_load,
  output logic [$clog2(NUM_CHUNKS)-1:0]         rp_load_val,
  output logic                                  rp_inc,
  input  logic [READ_WIDTH_MUL*WRITE_WIDTH-1:0] mem_rdata,
  input  logic [READ_WIDTH_MUL*WRITE_WIDTH-1:0] w_data,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  output logic [WRITE_WIDTH-1:0]                out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int CNT_W = $clog2(NUM_CHUNKS) + 1;
  localparam int DOT_W = dot_width(WRITE_WIDTH, READ_WIDTH_MUL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  localparam logic signed [ACC_WIDTH:0] OUT_HI =
    {{(ACC_WIDTH-WRITE_WIDTH+2){1'b0}}, {(WRITE_WIDTH-1){1'b1}}};
`ifdef CHUNK_DOT_RELU_EN
  localparam logic signed [ACC_WIDTH:0] OUT_LO = '0;
`else
  localparam logic signed [ACC_WIDTH:0] OUT_LO =
    {{(ACC_WIDTH-WRITE_WIDTH+2){1'b1}}, {(WRITE_WIDTH-1){1'b0}}};
`endif

  state_e                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [WRITE_WIDTH-1:0]  out_data_q, out_data_d;
  logic [DOT_W-1:0]        dot_q;
  logic                    dot_clr_s;
  logic                    dot_ld_s;
  logic                    last_s;
  logic [ACC_WIDTH-1:0]    dot_ext_s;
  logic signed [ACC_WIDTH:0] rnd_s;
  logic signed [ACC_WIDTH:0] rq_sum_s;
  logic signed [ACC_WIDTH:0] rq_r_s;

  assign last_s    = (remaining_q == CNT_ONE);
  assign dot_ext_s = {{(ACC_WIDTH-DOT_W){dot_q[DOT_W-1]}}, dot_q};

  chunk_dot #(
    .WRITE_WIDTH   (WRITE_WIDTH),
    .READ_WIDTH_MUL(READ_WIDTH_MUL),
    .DOT_W         (DOT_W)
  ) u_dot (
    .clk  (clk),
    .rst  (rst),
    .clr_i(dot_clr_s),
    .ld_i (dot_ld_s),
    .a_i  (mem_rdata),
    .b_i  (w_data),
    .dot_o(dot_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (num_chunks == '0) ? ST_DRAIN : ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (w_valid && last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_DRAIN:   state_d = ST_REQUANT;
      ST_REQUANT: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode; pointer pulses are suppressed while reset is asserted.
  always_comb begin
    busy        = 1'b0;
    w_ready     = 1'b0;
    out_valid   = 1'b0;
    rp_load     = 1'b0;
    rp_load_val = '0;
    rp_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !rst) begin
          rp_load     = 1'b1;
          rp_load_val = base_chunk;
        end else begin
          rp_load     = 1'b0;
        end
      end
      ST_MAC: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        if (w_valid && !last_s && !rst) begin
          rp_inc = 1'b1;
        end else begin
          rp_inc = 1'b0;
        end
      end
      ST_DRAIN:   busy = 1'b1;
      ST_REQUANT: busy = 1'b1;
      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default:    busy = 1'b0;
    endcase
  end

  // Round-half-up arithmetic shift, one extra bit so the rounding add cannot wrap.
  always_comb begin
    if (shift != 5'd0) begin
      rnd_s = (ACC_WIDTH+1)'(1'b1) << (shift - 5'd1);
    end else begin
      rnd_s = '0;
    end
    rq_sum_s = $signed({acc_q[ACC_WIDTH-1], acc_q}) + rnd_s;
    rq_r_s   = rq_sum_s >>> shift;
  end

  // Datapath next-state: accumulator, chunk counter, requantised output.
  always_comb begin
    acc_d       = acc_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    dot_clr_s   = 1'b0;
    dot_ld_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d       = bias;
          remaining_d = num_chunks;
          dot_clr_s   = 1'b1;
        end else begin
          dot_clr_s   = 1'b0;
        end
      end
      ST_MAC: begin
        if (w_valid) begin
          acc_d       = acc_q + dot_ext_s;
          remaining_d = remaining_q - CNT_ONE;
          dot_ld_s    = 1'b1;
        end else begin
          dot_ld_s    = 1'b0;
        end
      end
      ST_DRAIN: acc_d = acc_q + dot_ext_s;
      ST_REQUANT: begin
        if (rq_r_s > OUT_HI) begin
          out_data_d = OUT_HI[WRITE_WIDTH-1:0];
        end else if (rq_r_s < OUT_LO) begin
          out_data_d = OUT_LO[WRITE_WIDTH-1:0];
        end else begin
          out_data_d = rq_r_s[WRITE_WIDTH-1:0];
        end
      end
      ST_OUT:   out_data_d = out_data_q;
      default:  acc_d = acc_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data = out_data_q;

endmodule
